decl_check: RTL

- Streaming recogniser for C-style variable declarations. It consumes one ASCII character per valid cycle and flags each complete statement, terminated by `;`, as valid or invalid.
- It generalises the single-keyword `int` checker in three ways:
  - two type keywords;
  - optional array suffixes;
  - a bounded identifier length.
- It also reports how many variables each valid statement declared.
- It sits in the P1 text-processing exercises and is driven directly by a character-feeding bench.

---
 rtl/decl_check.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/decl_check.sv
// Streaming recogniser for C-style `int`/`char` declarations. One character per valid cycle;
// each `;` yields a registered out (valid, with variable count) or err pulse.
module decl_check #(
   parameter int unsigned MAX_ID_LEN = 8,
   parameter bit          ARRAY_EN   = 1'b1,
   parameter int unsigned CNT_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       in,
   input  logic             in_valid,
   output logic             out,
   output logic             err,
   output logic [CNT_W-1:0] var_cnt
);

   // Length counter must hold MAX_ID_LEN+1 (overflow marker) and the keyword index 4.
   localparam int unsigned LW = ($clog2(MAX_ID_LEN + 2) > 3) ? $clog2(MAX_ID_LEN + 2) : 3;
   localparam logic [LW-1:0] LEN_MAX = LW'(MAX_ID_LEN);
   localparam logic [LW-1:0] LEN_OVF = LW'(MAX_ID_LEN + 1);

   typedef enum logic [3:0] {
      StStart, StKw, StKwWs, StId, StIdEnd, StLbr, StNum, StNumEnd, StDeclEnd, StSep, StErr
   } state_e;

   state_e           state_q, state_d;
   logic [LW-1:0]    len_q, len_d;
   logic             sel_q, sel_d;
   logic             pm_int_q, pm_int_d;
   logic             pm_char_q, pm_char_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] var_cnt_q, var_cnt_d;
   logic             out_q, out_d;
   logic             err_q, err_d;

   logic is_ws, is_digit, is_alpha, is_idstart, is_idch, is_semi, is_comma, is_lbr, is_rbr;
   logic id_bad, bad;
   logic [LW-1:0]    kw_len;
   logic [CNT_W-1:0] cnt_inc;

   function automatic logic [7:0] kw_ch(input logic sel, input logic [2:0] idx);
      logic [7:0] c;
      if (sel) begin
         case (idx)
            3'd0:    c = "c";
            3'd1:    c = "h";
            3'd2:    c = "a";
            default: c = "r";
         endcase
      end else begin
         case (idx)
            3'd0:    c = "i";
            3'd1:    c = "n";
            default: c = "t";
         endcase
      end
      return c;
   endfunction

   always_comb begin
      is_ws      = (in == 8'h20) || (in == 8'h09);
      is_digit   = (in >= "0") && (in <= "9");
      is_alpha   = ((in >= "a") && (in <= "z")) || ((in >= "A") && (in <= "Z"));
      is_idstart = is_alpha || (in == "_");
      is_idch    = is_idstart || is_digit;
      is_semi    = (in == ";");
      is_comma   = (in == ",");
      is_lbr     = (in == "[");
      is_rbr     = (in == "]");
      kw_len     = sel_q ? LW'(4) : LW'(3);
      cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      // Identifier equal to a keyword, or too long, is rejected when it closes.
      id_bad     = (len_q > LEN_MAX) || (pm_int_q && (len_q == LW'(3)))
                   || (pm_char_q && (len_q == LW'(4)));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StStart;
         len_q     <= '0;
         sel_q     <= 1'b0;
         pm_int_q  <= 1'b0;
         pm_char_q <= 1'b0;
         cnt_q     <= '0;
         var_cnt_q <= '0;
         out_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         sel_q     <= sel_d;
         pm_int_q  <= pm_int_d;
         pm_char_q <= pm_char_d;
         cnt_q     <= cnt_d;
         var_cnt_q <= var_cnt_d;
         out_q     <= out_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      sel_d     = sel_q;
      pm_int_d  = pm_int_q;
      pm_char_d = pm_char_q;
      cnt_d     = cnt_q;
      var_cnt_d = var_cnt_q;
      out_d     = 1'b0;
      err_d     = 1'b0;
      bad       = 1'b0;
      if (in_valid) begin
         unique case (state_q)
            StStart: begin
               if (in == "i" || in == "c") begin
                  state_d = StKw;
                  sel_d   = (in == "c");
                  len_d   = LW'(1);
               end else if (!is_ws && !is_semi) begin
                  bad = 1'b1;
               end
            end
            StKw: begin
               if (len_q == kw_len) begin
                  if (is_ws) state_d = StKwWs;
                  else       bad = 1'b1;
               end else if (in == kw_ch(sel_q, len_q[2:0])) begin
                  len_d = len_q + LW'(1);
               end else begin
                  bad = 1'b1;
               end
            end
            StKwWs, StSep: begin
               if (is_idstart) begin
                  state_d   = StId;
                  len_d     = LW'(1);
                  pm_int_d  = (in == "i");
                  pm_char_d = (in == "c");
               end else if (!is_ws) begin
                  bad = 1'b1;
               end
            end
            StId: begin
               if (is_idch) begin
                  len_d     = (len_q == LEN_OVF) ? len_q : len_q + LW'(1);
                  pm_int_d  = pm_int_q && (len_q < LW'(3)) && (in == kw_ch(1'b0, len_q[2:0]));
                  pm_char_d = pm_char_q && (len_q < LW'(4)) && (in == kw_ch(1'b1, len_q[2:0]));
               end else if ((is_ws || is_comma || is_semi || (is_lbr && ARRAY_EN)) && !id_bad) begin
                  cnt_d = cnt_inc;
                  if (is_ws)         state_d = StIdEnd;
                  else if (is_comma) state_d = StSep;
                  else if (is_lbr)   state_d = StLbr;
                  else begin
                     state_d   = StStart;
                     out_d     = 1'b1;
                     var_cnt_d = cnt_inc;
                  end
               end else begin
                  bad = 1'b1;
               end
            end
            StIdEnd, StDeclEnd: begin
               if (is_comma) begin
                  state_d = StSep;
               end else if (is_lbr && ARRAY_EN && state_q == StIdEnd) begin
                  state_d = StLbr;
               end else if (is_semi) begin
                  state_d   = StStart;
                  out_d     = 1'b1;
                  var_cnt_d = cnt_q;
               end else if (!is_ws) begin
                  bad = 1'b1;
               end
            end
            StLbr: begin
               if (is_digit)    state_d = StNum;
               else if (!is_ws) bad = 1'b1;
            end
            StNum, StNumEnd: begin
               if (is_rbr)                              state_d = StDeclEnd;
               else if (is_ws)                          state_d = StNumEnd;
               else if (!(is_digit && state_q == StNum)) bad = 1'b1;
            end
            StErr: begin
               if (is_semi) begin
                  state_d = StStart;
                  err_d   = 1'b1;
               end
            end
            default: bad = 1'b1;
         endcase
         if (bad) begin
            if (is_semi) begin
               state_d = StStart;
               err_d   = 1'b1;
            end else begin
               state_d = StErr;
            end
         end
         if (state_d == StStart) begin
            cnt_d = '0;
            len_d = '0;
         end
      end
   end

   always_comb begin
      out     = out_q;
      err     = err_q;
      var_cnt = var_cnt_q;
   end

endmodule
